// File: rtl/pipelined_math_pkg.sv
// Shared elaboration-time helpers for the chunked pipelined adder and its output deskew stage.
package pipelined_math_pkg;

  function automatic int unsigned ceil_division(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Cycles from chunk 0 leaving the adder until its top carry is available.
  function automatic int unsigned deskew_latency(input int unsigned width, input int unsigned chunk);
    int unsigned extra;
    extra = ((width % chunk) == 0) ? 1 : 0;
    return ceil_division(width, chunk) - 1 + extra;
  endfunction

endpackage

// File: rtl/adder_deskew_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH=0 degenerates to a wire.
module delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 1,
  localparam int unsigned SW   = (DEPTH > 0) ? DEPTH : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  d,
  output logic [W-1:0]  q,
  output logic [SW-1:0] stages
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ en;
    assign q      = d;
    assign stages = '0;
  end else begin : g_regs
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = d;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          stage_q[k] <= '0;
        end
      end else if (en) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          stage_q[k] <= stage_d[k];
        end
      end
    end

    assign q = stage_q[DEPTH-1];

    // Per-stage occupancy, used as in-flight flags on the valid line.
    always_comb begin
      stages = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stages[k] = |stage_q[k];
      end
    end
  end

endmodule

// File: rtl/adder_deskew.sv
// Realigns the skewed chunk outputs of the pipelined adder into one WIDTH+1-bit word with a valid flag.
module adder_deskew
  import pipelined_math_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           in_valid,
  input  logic [WIDTH:0] sum,
  output logic [WIDTH:0] out,
  output logic           out_valid,
  output logic           busy
);

  localparam int unsigned N   = ceil_division(WIDTH, CHUNK);
  localparam int unsigned L   = deskew_latency(WIDTH, CHUNK);
  localparam int unsigned VSW = (L > 0) ? L : 1;

  logic [VSW-1:0] valid_stages;

  // Chunk i arrives i cycles late, so it waits L-i cycles to line up with the top carry.
  for (genvar i = 0; i < N; i++) begin : g_chunk
    localparam int unsigned LB    = i * CHUNK;
    localparam int unsigned CW    = min(CHUNK, WIDTH - LB);
    localparam int unsigned DEPTH = L - i;
    localparam int unsigned SW    = (DEPTH > 0) ? DEPTH : 1;

    logic [SW-1:0] unused_stages;

    delay_line #(
      .DEPTH (DEPTH),
      .W     (CW)
    ) u_chunk_dl (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .d      (sum[LB +: CW]),
      .q      (out[LB +: CW]),
      .stages (unused_stages)
    );
  end

  assign out[WIDTH] = sum[WIDTH];

  delay_line #(
    .DEPTH (L),
    .W     (1)
  ) u_valid_dl (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .d      (in_valid),
    .q      (out_valid),
    .stages (valid_stages)
  );

  assign busy = |valid_stages;

endmodule

// File: tb/tb_adder_deskew.sv
// Bench for adder_deskew: three configurations driven through a model of the adder's output skew.
module tb_adder_deskew;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en8, en10, en3;
  logic        iv8, iv10, iv3;
  logic [8:0]  sum8, out8;
  logic [10:0] sum10, out10;
  logic [3:0]  sum3, out3;
  logic        ov8, ov10, ov3;
  logic        busy8, busy10, busy3;

  adder_deskew #(.WIDTH(8), .CHUNK(4)) u_d8 (
    .clk(clk), .rst(rst), .en(en8), .in_valid(iv8), .sum(sum8),
    .out(out8), .out_valid(ov8), .busy(busy8)
  );

  adder_deskew #(.WIDTH(10), .CHUNK(4)) u_d10 (
    .clk(clk), .rst(rst), .en(en10), .in_valid(iv10), .sum(sum10),
    .out(out10), .out_valid(ov10), .busy(busy10)
  );

  adder_deskew #(.WIDTH(3), .CHUNK(4)) u_d3 (
    .clk(clk), .rst(rst), .en(en3), .in_valid(iv3), .sum(sum3),
    .out(out3), .out_valid(ov3), .busy(busy3)
  );

  localparam int CHUNK = 4;

  int vectors = 0;
  int errors  = 0;

  // Configuration index 0: 8/4, 1: 10/4, 2: 3/4; latencies follow the chunk/carry timing rules.
  int cfg_w [3] = '{8, 10, 3};
  int cfg_l [3] = '{2, 2, 0};
  int cyc   [3];

  // Operations keyed by the en-cycle in which chunk 0 leaves the adder.
  logic        vq [3][512];
  logic [10:0] rq [3][512];
  logic [10:0] gq [3][512];

  function automatic logic [10:0] width_mask(input int s);
    return 11'h7FF >> (10 - cfg_w[s]);
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 512; k++)
        vq[s][k] = 1'b0;
  endtask

  task automatic plan(input int s, input int at, input logic [10:0] r);
    vq[s][at] = 1'b1;
    rq[s][at] = r & width_mask(s);
  endtask

  // One wall-clock cycle on configuration s; e=0 stalls the adder and the deskew together.
  task automatic step(input int s, input logic e);
    logic [10:0] bus;
    logic [10:0] act_o;
    logic [10:0] exp_o;
    logic        act_v, act_b, exp_v, exp_b;
    int          k, c, l, w;
    c = cyc[s];
    l = cfg_l[s];
    w = cfg_w[s];
    bus = '0;
    for (int b = 0; b <= w; b++) begin
      k = (b == w) ? c - l : c - b / CHUNK;
      if (k >= 0 && vq[s][k]) bus[b] = rq[s][k][b];
      else                    bus[b] = gq[s][(k < 0) ? 0 : k][b];
    end
    @(negedge clk);
    case (s)
      0: begin en8  = e; iv8  = vq[s][c]; sum8  = bus[8:0];  end
      1: begin en10 = e; iv10 = vq[s][c]; sum10 = bus[10:0]; end
      default: begin en3 = e; iv3 = vq[s][c]; sum3 = bus[3:0]; end
    endcase
    #2;
    exp_v = (c - l >= 0) ? vq[s][c - l] : 1'b0;
    exp_o = (c - l >= 0) ? rq[s][c - l] : 11'h000;
    exp_b = 1'b0;
    for (int j = 1; j <= l; j++)
      if (c - j >= 0) exp_b = exp_b | vq[s][c - j];
    case (s)
      0: begin act_v = ov8;  act_b = busy8;  act_o = {2'b00, out8};   end
      1: begin act_v = ov10; act_b = busy10; act_o = out10;           end
      default: begin act_v = ov3; act_b = busy3; act_o = {7'b0000000, out3}; end
    endcase
    vectors++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL out_valid cfg%0d ecyc%0d: got %b expected %b", s, c, act_v, exp_v);
    end
    vectors++;
    if (act_b !== exp_b) begin
      errors++;
      $display("FAIL busy cfg%0d ecyc%0d: got %b expected %b", s, c, act_b, exp_b);
    end
    if (exp_v) begin
      vectors++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL out cfg%0d ecyc%0d: got %h expected %h", s, c, act_o, exp_o);
      end
    end
    @(posedge clk);
    if (e) cyc[s] = cyc[s] + 1;
    #1;
    case (s)
      0: en8 = 1'b0;
      1: en10 = 1'b0;
      default: en3 = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en8 = 1'b0; en10 = 1'b0; en3 = 1'b0;
    iv8 = 1'b0; iv10 = 1'b0; iv3 = 1'b0;
    sum8 = '0; sum10 = '0; sum3 = '0;
    for (int s = 0; s < 3; s++) cyc[s] = 0;
    clear_model();
    #3;
    vectors++;
    if ({ov8, ov10, ov3, busy8, busy10, busy3} !== 6'b000000) begin
      errors++;
      $display("FAIL reset flags: got %b expected 000000", {ov8, ov10, ov3, busy8, busy10, busy3});
    end
    vectors++;
    if (out8 !== 9'h000 || out10 !== 11'h000) begin
      errors++;
      $display("FAIL reset out: got %h/%h expected 000/000", out8, out10);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_carry_8();
    plan(0, cyc[0], 11'h100);
    for (int n = 0; n < 5; n++) step(0, 1'b1);
  endtask

  task automatic test_partial_chunk_10();
    plan(1, cyc[1], 11'h3A5);
    for (int n = 0; n < 4; n++) step(1, 1'b1);
  endtask

  task automatic test_back_to_back();
    plan(0, cyc[0],     11'h012);
    plan(0, cyc[0] + 1, 11'h134);
    plan(0, cyc[0] + 2, 11'h0FF);
    for (int n = 0; n < 7; n++) step(0, 1'b1);
  endtask

  task automatic test_stall();
    plan(0, cyc[0], 11'h1C3);
    step(0, 1'b1);
    for (int n = 0; n < 3; n++) step(0, 1'b0);
    for (int n = 0; n < 4; n++) step(0, 1'b1);
  endtask

  task automatic test_passthrough();
    plan(2, cyc[2], 11'h00B);
    step(2, 1'b1);
    plan(2, cyc[2], 11'h004);
    step(2, 1'b1);
    step(2, 1'b1);
  endtask

  task automatic test_reset_midflight();
    plan(0, cyc[0], 11'h0AA);
    step(0, 1'b1);
    rst = 1'b0;
    #1;
    vectors++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b busy=%b expected 0/0", ov8, busy8);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 5; n++) step(0, 1'b1);
  endtask

  task automatic test_random();
    int base;
    for (int s = 0; s < 3; s++) begin
      base = cyc[s];
      for (int k = 0; k < 64; k++)
        if ($urandom_range(1, 0) == 1) plan(s, base + k, 11'($urandom));
      for (int n = 0; n < 80; n++) step(s, ($urandom_range(3, 0) != 0));
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 512; k++)
        gq[s][k] = 11'($urandom) & width_mask(s);
    test_reset();
    test_carry_8();
    test_partial_chunk_10();
    test_back_to_back();
    test_stall();
    test_passthrough();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
